// File: rtl/cfi_checker_mc_if.sv
// Log-table read bus between the CFI checker (master) and the memory (slave).
// Ports: o_rqAccess/o_logAddr carry the read request; i_logDone/i_logData return the word.
// Names are seen from the checker side; the memory drives the i_* members.
interface cfi_checker_mc_if #(
  parameter int N_ADDR_WIDTH = 32,
  parameter int N_DATA_WIDTH = 32
);
  logic                    o_rqAccess;
  logic [N_ADDR_WIDTH-1:0] o_logAddr;
  logic                    i_logDone;
  logic [N_DATA_WIDTH-1:0] i_logData;

  modport master (
    output o_rqAccess, o_logAddr,
    input  i_logDone, i_logData
  );

  modport slave (
    input  o_rqAccess, o_logAddr,
    output i_logDone, i_logData
  );
endinterface

// File: rtl/cfi_checker_mc.sv
// Multi-line CFI checker: drains branch-log words from a circular table and checks each
// against an N-line CFG table (range or exact match), reporting the first violation.
// Ports: clk/rst; i_trigger/i_logAddrptr producer pointer; bus = log read handshake;
// i_cfg* table load/clear; i_clrErr; o_inv* violation report; o_busy; o_checkedCnt.
module cfi_checker_mc #(
  parameter int                      N_ADDR_WIDTH      = 32,
  parameter int                      N_DATA_WIDTH      = 32,
  parameter int                      N_CFG_LINES       = 16,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFF400,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND  = 32'h1FEFF7FC,
  parameter int                      MATCH_MODE        = 0,
  parameter int                      HALT_ON_ERR       = 1,
  localparam int                     CFG_IW            = (N_CFG_LINES > 1) ? $clog2(N_CFG_LINES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_trigger,
  input  logic [N_ADDR_WIDTH-1:0] i_logAddrptr,
  cfi_checker_mc_if.master        bus,
  input  logic                    i_cfgWe,
  input  logic [CFG_IW-1:0]       i_cfgIdx,
  input  logic [N_DATA_WIDTH-1:0] i_cfgInit,
  input  logic [N_DATA_WIDTH-1:0] i_cfgEnd,
  input  logic                    i_cfgClr,
  input  logic                    i_clrErr,
  output logic                    o_invBranch,
  output logic [N_ADDR_WIDTH-1:0] o_invAddr,
  output logic [N_DATA_WIDTH-1:0] o_invData,
  output logic                    o_busy,
  output logic [31:0]             o_checkedCnt
);

  typedef enum logic [1:0] {IDLE, READ_LOG, SRCH_CFG, VIOLATE} state_t;

  state_t                  state, state_nxt;
  logic [N_ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, last_addr;
  logic [N_DATA_WIDTH-1:0] log_word;
  logic [CFG_IW-1:0]       idx;
  logic [N_DATA_WIDTH-1:0] cfg_lo [N_CFG_LINES];
  logic [N_DATA_WIDTH-1:0] cfg_hi [N_CFG_LINES];
  logic [N_CFG_LINES-1:0]  cfg_vld;
  logic                    pending, trig_ok, cfg_wr, line_hit, last_line, halted;

  // Only aligned pointers inside the table are believable; anything else is dropped.
  assign trig_ok = i_trigger && (i_logAddrptr[1:0] == 2'b00) &&
                   (i_logAddrptr >= LOGTABLE_ADDRINIT) && (i_logAddrptr <= LOGTABLE_ADDREND);
  assign pending    = (wr_ptr != rd_ptr);
  assign rd_ptr_nxt = (rd_ptr == LOGTABLE_ADDREND) ? LOGTABLE_ADDRINIT
                                                   : rd_ptr + N_ADDR_WIDTH'(4);
  assign last_line  = (idx == CFG_IW'(N_CFG_LINES - 1));
  assign halted     = (HALT_ON_ERR != 0) && o_invBranch;
  // Out-of-range indices (non power-of-two depth) are silently ignored.
  assign cfg_wr     = i_cfgWe && !i_cfgClr &&
                      ({1'b0, i_cfgIdx} < (CFG_IW + 1)'(N_CFG_LINES));

  // One CFG line examined per cycle; an inverted range (hi < lo) can never hit.
  always_comb begin
    line_hit = 1'b0;
    if (cfg_vld[idx]) begin
      if (MATCH_MODE != 0) line_hit = (log_word == cfg_lo[idx]);
      else                 line_hit = (log_word >= cfg_lo[idx]) && (log_word <= cfg_hi[idx]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending && !halted) state_nxt = READ_LOG;
      READ_LOG: if (bus.i_logDone)      state_nxt = SRCH_CFG;
      SRCH_CFG: begin
        if (line_hit)       state_nxt = IDLE;
        else if (last_line) state_nxt = VIOLATE;
      end
      VIOLATE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request is decoded straight from state so an async reset drops it at once.
  assign bus.o_rqAccess = (state == READ_LOG);
  assign bus.o_logAddr  = rd_ptr;
  assign o_busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= LOGTABLE_ADDRINIT;
      rd_ptr       <= LOGTABLE_ADDRINIT;
      last_addr    <= LOGTABLE_ADDRINIT;
      log_word     <= '0;
      idx          <= '0;
      o_invBranch  <= 1'b0;
      o_invAddr    <= '0;
      o_invData    <= '0;
      o_checkedCnt <= '0;
    end else begin
      state <= state_nxt;
      if (trig_ok) wr_ptr <= i_logAddrptr;
      if (state == READ_LOG && bus.i_logDone) begin
        log_word  <= bus.i_logData;
        last_addr <= rd_ptr;
        rd_ptr    <= rd_ptr_nxt;
        idx       <= '0;
      end
      if (state == SRCH_CFG && !line_hit && !last_line) idx <= idx + CFG_IW'(1);
      if ((state == SRCH_CFG && line_hit) || state == VIOLATE)
        o_checkedCnt <= o_checkedCnt + 32'd1;
      // First violation is sticky; a clear in the same cycle lets the new one in.
      if (state == VIOLATE && (!o_invBranch || i_clrErr)) begin
        o_invBranch <= 1'b1;
        o_invAddr   <= last_addr;
        o_invData   <= log_word;
      end else if (i_clrErr) begin
        o_invBranch <= 1'b0;
        o_invAddr   <= '0;
        o_invData   <= '0;
      end
    end
  end

  // Clear beats write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cfg_vld <= '0;
    else if (i_cfgClr) cfg_vld <= '0;
    else if (cfg_wr)   cfg_vld[i_cfgIdx] <= 1'b1;
  end

  // Bounds need no reset: they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      cfg_lo[i_cfgIdx] <= i_cfgInit;
      cfg_hi[i_cfgIdx] <= i_cfgEnd;
    end
  end

endmodule

// File: tb/tb_cfi_checker_mc.sv
// Bench for cfi_checker_mc: three instances (range/halt, range/continue, exact/halt),
// each with its own log memory model. Read addresses are scoreboarded against a queue
// filled when stimulus is issued; verdicts are checked inline per scenario task.
module tb_cfi_checker_mc;
  localparam logic [31:0] LOG_INIT = 32'h1FEFF400;
  localparam logic [31:0] LOG_END  = 32'h1FEFF7FC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  trig = '0, we = '0, cclr = '0, clr = '0, done = '0, resp_en = '1;
  logic [31:0] ptr [3], rdata [3], cinit [3], cend [3];
  logic [3:0]  cidx [3];
  int          lat [3];
  logic [31:0] mem [3][256];
  logic [31:0] exp_addr [3][$];

  wire [2:0]  rq, busy, inv;
  wire [31:0] laddr [3], inv_addr [3], inv_data [3], cnt [3];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MM  = (g == 2) ? 1 : 0;
    localparam int HOE = (g == 1) ? 0 : 1;

    cfi_checker_mc_if #(.N_ADDR_WIDTH(32), .N_DATA_WIDTH(32)) bus ();
    assign bus.i_logDone = done[g];
    assign bus.i_logData = rdata[g];
    assign rq[g]    = bus.o_rqAccess;
    assign laddr[g] = bus.o_logAddr;

    cfi_checker_mc #(
      .N_ADDR_WIDTH(32), .N_DATA_WIDTH(32), .N_CFG_LINES(16),
      .LOGTABLE_ADDRINIT(LOG_INIT), .LOGTABLE_ADDREND(LOG_END),
      .MATCH_MODE(MM), .HALT_ON_ERR(HOE)
    ) dut (
      .clk(clk), .rst(rst),
      .i_trigger(trig[g]), .i_logAddrptr(ptr[g]),
      .bus(bus),
      .i_cfgWe(we[g]), .i_cfgIdx(cidx[g]), .i_cfgInit(cinit[g]), .i_cfgEnd(cend[g]),
      .i_cfgClr(cclr[g]), .i_clrErr(clr[g]),
      .o_invBranch(inv[g]), .o_invAddr(inv_addr[g]), .o_invData(inv_data[g]),
      .o_busy(busy[g]), .o_checkedCnt(cnt[g])
    );

    // Memory model: answers a request lat cycles later and scoreboards its address.
    initial begin : resp
      int c;
      logic [31:0] e, off;
      c = 0;
      forever begin
        @(negedge clk);
        if (resp_en[g] && !rst) begin
          if (done[g]) begin
            done[g] = 1'b0;
            c = 0;
          end else if (rq[g]) begin
            c++;
            if (c >= lat[g]) begin
              off = (laddr[g] - LOG_INIT) >> 2;
              rdata[g] = mem[g][off[7:0]];
              done[g] = 1'b1;
              n_tests++;
              if (exp_addr[g].size() == 0) begin
                n_fail++;
                $display("FAIL read_addr dut%0d: request at %h, none expected", g, laddr[g]);
              end else begin
                e = exp_addr[g].pop_front();
                if (laddr[g] !== e) begin
                  n_fail++;
                  $display("FAIL read_addr dut%0d: got %h expected %h", g, laddr[g], e);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input int d, input int idx, input logic [31:0] lo, input logic [31:0] hi);
    @(posedge clk); #1;
    we[d] = 1'b1; cidx[d] = 4'(idx); cinit[d] = lo; cend[d] = hi;
    @(posedge clk); #1;
    we[d] = 1'b0;
  endtask

  task automatic cfg_clear(input int d);
    @(posedge clk); #1; cclr[d] = 1'b1;
    @(posedge clk); #1; cclr[d] = 1'b0;
  endtask

  task automatic trigger(input int d, input logic [31:0] p);
    @(posedge clk); #1; trig[d] = 1'b1; ptr[d] = p;
    @(posedge clk); #1; trig[d] = 1'b0;
  endtask

  task automatic clr_err(input int d);
    @(posedge clk); #1; clr[d] = 1'b1;
    @(posedge clk); #1; clr[d] = 1'b0;
  endtask

  task automatic wait_cnt(input int d, input logic [31:0] t, input int budget);
    for (int i = 0; i < budget && cnt[d] !== t; i++) cyc(1);
  endtask

  task automatic wait_inv(input int d, input int budget);
    for (int i = 0; i < budget && inv[d] !== 1'b1; i++) cyc(1);
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget && done[d] !== 1'b1; i++) cyc(1);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({rq[d], busy[d], inv[d], laddr[d], inv_addr[d], inv_data[d], cnt[d]} !==
          {3'b000, LOG_INIT, 32'd0, 32'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset dut%0d: rq=%b busy=%b inv=%b addr=%h ia=%h id=%h cnt=%0d", d,
                 rq[d], busy[d], inv[d], laddr[d], inv_addr[d], inv_data[d], cnt[d]);
      end
    end
  endtask

  task automatic test_basic;
    cfg_write(0, 0, 32'h1000, 32'h1FFF);
    mem[0][0] = 32'h1800;
    exp_addr[0].push_back(LOG_INIT);
    trigger(0, 32'h1FEFF404);
    wait_cnt(0, 1, 50);
    cyc(3);
    n_tests++;
    if ({cnt[0], inv[0], busy[0], rq[0]} !== {32'd1, 3'b000}) begin
      n_fail++;
      $display("FAIL basic: cnt=%0d inv=%b busy=%b rq=%b, need 1/0/0/0", cnt[0], inv[0], busy[0], rq[0]);
    end
  endtask

  task automatic test_search_latency;
    int k;
    cfg_clear(0);
    cfg_write(0, 0, 32'h0000, 32'h00FF);
    cfg_write(0, 1, 32'h0100, 32'h01FF);
    cfg_write(0, 2, 32'h0200, 32'h02FF);
    cfg_write(0, 3, 32'hA000, 32'hA0FF);
    mem[0][1] = 32'hA010;
    exp_addr[0].push_back(32'h1FEFF404);
    trigger(0, 32'h1FEFF408);
    wait_done(0, 50);
    k = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); k++; if (!busy[0]) break; end
    n_tests++;
    if (k != 4) begin n_fail++; $display("FAIL match_line3_latency: %0d cycles, need 4", k); end
    n_tests++;
    if (cnt[0] !== 32'd2 || inv[0] !== 1'b0) begin
      n_fail++; $display("FAIL match_line3_result: cnt=%0d inv=%b, need 2/0", cnt[0], inv[0]);
    end
  endtask

  task automatic test_violation;
    int k;
    mem[0][2] = 32'hB000;
    exp_addr[0].push_back(32'h1FEFF408);
    trigger(0, 32'h1FEFF40C);
    wait_done(0, 50);
    k = 0;
    for (int i = 0; i < 60; i++) begin cyc(1); k++; if (inv[0]) break; end
    n_tests++;
    if (k != 17) begin n_fail++; $display("FAIL violate_latency: %0d cycles, need 17", k); end
    n_tests++;
    if ({inv_addr[0], inv_data[0], cnt[0]} !== {32'h1FEFF408, 32'hB000, 32'd3}) begin
      n_fail++;
      $display("FAIL violate_report: addr=%h data=%h cnt=%0d, need 1FEFF408/B000/3",
               inv_addr[0], inv_data[0], cnt[0]);
    end
    clr_err(0);
    n_tests++;
    if ({inv[0], inv_addr[0], inv_data[0]} !== 65'd0) begin
      n_fail++; $display("FAIL clr_err: inv=%b addr=%h data=%h, need zeros", inv[0], inv_addr[0], inv_data[0]);
    end
  endtask

  task automatic test_halt;
    int seen;
    mem[0][3] = 32'hB000; mem[0][4] = 32'hA020; mem[0][5] = 32'hA030;
    exp_addr[0].push_back(32'h1FEFF40C);
    trigger(0, 32'h1FEFF418);
    wait_inv(0, 100);
    seen = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); if (rq[0]) seen++; end
    n_tests++;
    if (seen != 0 || cnt[0] !== 32'd4 || inv[0] !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold: rq cycles=%0d cnt=%0d inv=%b, need 0/4/1", seen, cnt[0], inv[0]);
    end
    exp_addr[0].push_back(32'h1FEFF410);
    exp_addr[0].push_back(32'h1FEFF414);
    clr_err(0);
    wait_cnt(0, 6, 100);
    n_tests++;
    if (cnt[0] !== 32'd6 || inv[0] !== 1'b0) begin
      n_fail++; $display("FAIL halt_resume: cnt=%0d inv=%b, need 6/0", cnt[0], inv[0]);
    end
  endtask

  task automatic test_continue;
    lat[1] = 1;
    cfg_write(1, 0, 32'h0000, 32'h00FF);
    cfg_write(1, 1, 32'h0100, 32'h01FF);
    cfg_write(1, 2, 32'h0200, 32'h02FF);
    cfg_write(1, 3, 32'hA000, 32'hA0FF);
    mem[1][0] = 32'hB000; mem[1][1] = 32'hA020; mem[1][2] = 32'hC000;
    for (int i = 0; i < 3; i++) exp_addr[1].push_back(LOG_INIT + 32'(4 * i));
    trigger(1, 32'h1FEFF40C);
    wait_cnt(1, 3, 200);
    n_tests++;
    if ({cnt[1], inv[1], inv_addr[1], inv_data[1]} !== {32'd3, 1'b1, LOG_INIT, 32'hB000}) begin
      n_fail++;
      $display("FAIL continue: cnt=%0d inv=%b addr=%h data=%h, need 3/1/1FEFF400/B000",
               cnt[1], inv[1], inv_addr[1], inv_data[1]);
    end
    clr_err(1);
  endtask

  task automatic test_wrap;
    mem[1][0] = 32'h0;
    for (int i = 3; i < 255; i++) exp_addr[1].push_back(LOG_INIT + 32'(4 * i));
    trigger(1, LOG_END);
    wait_cnt(1, 255, 4000);
    n_tests++;
    if (cnt[1] !== 32'd255 || laddr[1] !== LOG_END) begin
      n_fail++; $display("FAIL drain_to_end: cnt=%0d addr=%h, need 255/%h", cnt[1], laddr[1], LOG_END);
    end
    exp_addr[1].push_back(LOG_END);
    exp_addr[1].push_back(LOG_INIT);
    trigger(1, 32'h1FEFF404);
    wait_cnt(1, 257, 100);
    cyc(5);
    n_tests++;
    if ({cnt[1], busy[1], inv[1], laddr[1]} !== {32'd257, 2'b00, 32'h1FEFF404}) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d busy=%b inv=%b addr=%h, need 257/0/0/1FEFF404",
               cnt[1], busy[1], inv[1], laddr[1]);
    end
  endtask

  task automatic test_bad_trigger;
    logic [31:0] bad [4];
    bad[0] = 32'h1FEFF802; bad[1] = 32'h1FEFF406; bad[2] = 32'h1FEFF800; bad[3] = 32'h1FEFF3FC;
    for (int i = 0; i < 4; i++) begin
      trigger(1, bad[i]);
      cyc(8);
      n_tests++;
      if ({busy[1], rq[1], laddr[1], cnt[1]} !== {2'b00, 32'h1FEFF404, 32'd257}) begin
        n_fail++;
        $display("FAIL bad_trigger %h: busy=%b rq=%b addr=%h cnt=%0d", bad[i], busy[1], rq[1], laddr[1], cnt[1]);
      end
    end
  endtask

  task automatic test_range_inverted;
    cfg_clear(0);
    cfg_write(0, 0, 32'h5000, 32'h4000);
    mem[0][6] = 32'h4800;
    exp_addr[0].push_back(32'h1FEFF418);
    trigger(0, 32'h1FEFF41C);
    wait_cnt(0, 7, 100);
    n_tests++;
    if (inv[0] !== 1'b1 || inv_data[0] !== 32'h4800) begin
      n_fail++; $display("FAIL inverted_range: inv=%b data=%h, need 1/4800", inv[0], inv_data[0]);
    end
    clr_err(0);
    // Clear and write in the same cycle: the clear must win.
    @(posedge clk); #1;
    cclr[0] = 1'b1; we[0] = 1'b1; cidx[0] = 4'd0; cinit[0] = 32'h0; cend[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    cclr[0] = 1'b0; we[0] = 1'b0;
    mem[0][7] = 32'h1234;
    exp_addr[0].push_back(32'h1FEFF41C);
    trigger(0, 32'h1FEFF420);
    wait_cnt(0, 8, 100);
    n_tests++;
    if (inv[0] !== 1'b1 || inv_addr[0] !== 32'h1FEFF41C) begin
      n_fail++; $display("FAIL clr_priority: inv=%b addr=%h, need 1/1FEFF41C", inv[0], inv_addr[0]);
    end
    clr_err(0);
  endtask

  task automatic test_exact;
    cfg_write(2, 0, 32'h4000, 32'h0);
    mem[2][0] = 32'h4000; mem[2][1] = 32'h4004; mem[2][2] = 32'h4000;
    exp_addr[2].push_back(LOG_INIT);
    trigger(2, 32'h1FEFF404);
    wait_cnt(2, 1, 50);
    n_tests++;
    if (cnt[2] !== 32'd1 || inv[2] !== 1'b0) begin
      n_fail++; $display("FAIL exact_pass: cnt=%0d inv=%b, need 1/0", cnt[2], inv[2]);
    end
    exp_addr[2].push_back(32'h1FEFF404);
    trigger(2, 32'h1FEFF408);
    wait_cnt(2, 2, 100);
    n_tests++;
    if ({inv[2], inv_addr[2], inv_data[2]} !== {1'b1, 32'h1FEFF404, 32'h4004}) begin
      n_fail++; $display("FAIL exact_flag: inv=%b addr=%h data=%h, need 1/1FEFF404/4004", inv[2], inv_addr[2], inv_data[2]);
    end
    clr_err(2);
    cfg_clear(2);
    exp_addr[2].push_back(32'h1FEFF408);
    trigger(2, 32'h1FEFF40C);
    wait_cnt(2, 3, 100);
    n_tests++;
    if ({inv[2], inv_addr[2], inv_data[2]} !== {1'b1, 32'h1FEFF408, 32'h4000}) begin
      n_fail++; $display("FAIL exact_cleared_table: inv=%b addr=%h data=%h, need 1/1FEFF408/4000", inv[2], inv_addr[2], inv_data[2]);
    end
  endtask

  task automatic test_reset_midread;
    resp_en[0] = 1'b0;
    trigger(0, 32'h1FEFF424);
    for (int i = 0; i < 20 && rq[0] !== 1'b1; i++) cyc(1);
    n_tests++;
    if (rq[0] !== 1'b1 || laddr[0] !== 32'h1FEFF420) begin
      n_fail++; $display("FAIL midread_request: rq=%b addr=%h, need 1/1FEFF420", rq[0], laddr[0]);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (rq[0] !== 1'b0) begin n_fail++; $display("FAIL async_rq_drop: rq=%b, need 0", rq[0]); end
    n_tests++;
    if ({busy[0], inv[0], laddr[0], inv_addr[0], inv_data[0], cnt[0], cnt[1]} !==
        {2'b00, LOG_INIT, 32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b inv=%b addr=%h ia=%h id=%h cnt=%0d", busy[0], inv[0],
               laddr[0], inv_addr[0], inv_data[0], cnt[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; done[0] = 1'b1;
    @(posedge clk); #1; done[0] = 1'b0;
    cyc(5);
    n_tests++;
    if ({busy[0], rq[0], cnt[0]} !== {2'b00, 32'd0}) begin
      n_fail++; $display("FAIL late_done: busy=%b rq=%b cnt=%0d, need 0/0/0", busy[0], rq[0], cnt[0]);
    end
    resp_en[0] = 1'b1;
  endtask

  task automatic test_drain_complete;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (exp_addr[d].size() != 0) begin
        n_fail++; $display("FAIL missing_reads dut%0d: %0d outstanding, need 0", d, exp_addr[d].size());
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      ptr[d] = '0; rdata[d] = '0; cinit[d] = '0; cend[d] = '0; cidx[d] = '0; lat[d] = 2;
      for (int i = 0; i < 256; i++) mem[d][i] = '0;
    end
    #12 rst = 1'b0;
    cyc(2);
    test_reset();
    test_basic();
    test_search_latency();
    test_violation();
    test_halt();
    test_continue();
    test_wrap();
    test_bad_trigger();
    test_range_inverted();
    test_exact();
    test_reset_midread();
    test_drain_complete();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfi_checker_mc.md
Name: cfi_checker_mc

Overview:
- Parametrised successor of the single-range CFI checker.
- Drains branch-log words from a circular log table in memory through a request/done handshake.
- Checks each logged target against an N-line CFG table held in internal registers, loaded through a config write port.
- Supports range or exact match mode and a halt-or-continue error policy; reports the offending log address and data.

Parameters:
- N_ADDR_WIDTH, 32, address width of log pointers and bus address.
- N_DATA_WIDTH, 32, width of a log word and of CFG bounds.
- N_CFG_LINES, 16, CFG table depth (>=1); index width CFG_IW = max(1,$clog2(N_CFG_LINES)).
- LOGTABLE_ADDRINIT, 32'h1FEFF400, first log entry address (4-byte aligned).
- LOGTABLE_ADDREND, 32'h1FEFF7FC, last valid log entry address (inclusive, aligned).
- MATCH_MODE, 0, 0 = range (init<=data<=end), 1 = exact (data==init).
- HALT_ON_ERR, 1, 1 = stop draining after a violation until i_clrErr; 0 = flag and continue.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_trigger  in  1  pulse: latch i_logAddrptr as the log write pointer.
- i_logAddrptr  in  N_ADDR_WIDTH  producer write pointer (next free entry).
- o_rqAccess  out  1  read request to memory.
- o_logAddr  out  N_ADDR_WIDTH  log entry address being read.
- i_logDone  in  1  read complete; i_logData valid this cycle.
- i_logData  in  N_DATA_WIDTH  log word.
- i_cfgWe  in  1  CFG line write strobe.
- i_cfgIdx  in  CFG_IW  line index.
- i_cfgInit  in  N_DATA_WIDTH  line lower bound / exact value.
- i_cfgEnd  in  N_DATA_WIDTH  line upper bound (ignored in exact mode).
- i_cfgClr  in  1  invalidate all CFG lines.
- i_clrErr  in  1  clear sticky error and resume.
- o_invBranch  out  1  sticky violation flag.
- o_invAddr  out  N_ADDR_WIDTH  log address of first unacknowledged violation.
- o_invData  out  N_DATA_WIDTH  offending log word.
- o_busy  out  1  high in any state except IDLE.
- o_checkedCnt  out  32  entries checked since reset; wraps modulo 2^32.

Behaviour:
- Reset:
  - All outputs 0 except o_logAddr = LOGTABLE_ADDRINIT.
  - Write pointer and read pointer = LOGTABLE_ADDRINIT; all CFG valid bits 0; state IDLE.
  - Reset mid-read drops o_rqAccess immediately (asynchronous).
- Write pointer: updated on i_trigger only if the value is aligned and within [INIT, END]; otherwise ignored. Pending = (wr_ptr != rd_ptr).
- Read pointer advance: rd_ptr == LOGTABLE_ADDREND -> LOGTABLE_ADDRINIT; otherwise rd_ptr + 4.
- States:
  - IDLE -> READ_LOG when pending and not (HALT_ON_ERR and o_invBranch).
  - READ_LOG: o_rqAccess = 1 and o_logAddr = rd_ptr, stable until i_logDone. On i_logDone: capture i_logData, advance rd_ptr, clear line index -> SRCH_CFG. i_logDone outside READ_LOG is ignored.
  - SRCH_CFG: compare one line per cycle (line idx, valid bit required).
    - Match -> IDLE, o_checkedCnt+1.
    - No match and idx == N_CFG_LINES-1 -> VIOLATE; otherwise idx+1.
  - VIOLATE (1 cycle): if o_invBranch is 0, set it and load o_invAddr = address just read and o_invData; otherwise keep the first report. o_checkedCnt+1 -> IDLE.
- Latency: a match on line k returns to IDLE k+1 cycles after the i_logDone cycle; the violation flag is visible N_CFG_LINES+1 cycles after the i_logDone cycle.
- Range mode with i_cfgEnd < i_cfgInit: the line never matches. An all-invalid table flags every entry.
- CFG writes:
  - Accepted in any state; take effect the next cycle and set the line's valid bit.
  - i_cfgClr has priority over i_cfgWe in the same cycle.
- i_clrErr clears o_invBranch, o_invAddr and o_invData; if it coincides with VIOLATE, the new violation wins.
- i_trigger and i_logDone in the same cycle: both take effect.
- Overrun (producer laps reader) is not detected; the table is treated as empty when wr == rd.

Test Plan:
- Line0 = [0x1000,0x1FFF]; trigger ptr 0x1FEFF404; memory returns 0x1800 after 2 cycles -> one request at 0x1FEFF400, no error, o_checkedCnt = 1, back to IDLE, o_busy low.
- Range lines 0..3 loaded, line 3 = [0xA000,0xA0FF]; log word 0xA010 -> SRCH_CFG lasts 4 cycles; log word 0xB000 -> o_invBranch = 1, o_invAddr = entry address, o_invData = 0xB000.
- HALT_ON_ERR = 1: three pending entries, first invalid -> no further o_rqAccess until i_clrErr; then the remaining two are read. With HALT_ON_ERR = 0 all three are read and o_invAddr holds the first violation.
- rd_ptr at 0x1FEFF7FC, trigger ptr 0x1FEFF404 -> reads at 0x1FEFF7FC, 0x1FEFF400 then stops (wrap). Trigger ptr 0x1FEFF802 or misaligned -> ignored, no request.
- MATCH_MODE = 1, line0 init = 0x4000: word 0x4000 passes, 0x4004 flags. i_cfgClr then any word -> violation.
- Assert rst while o_rqAccess is high and i_logDone is pending -> o_rqAccess drops the same cycle; all outputs return to reset values; late i_logDone is ignored.
